// File: rtl/xgmii_mon_pkg.sv
// Shared constants and types for the XGMII receive link monitor.
// Holds XGMII control character codes, the IDLE word pattern, the
// per-channel frame FSM state type and the read-select encoding.
package xgmii_mon_pkg;

    localparam logic [7:0]  XGMII_START = 8'hFB;
    localparam logic [7:0]  XGMII_TERM  = 8'hFD;
    localparam logic [7:0]  XGMII_ERROR = 8'hFE;
    localparam logic [7:0]  XGMII_IDLE  = 8'h07;

    localparam logic [63:0] IDLE_D = {8{XGMII_IDLE}};
    localparam logic [7:0]  IDLE_C = 8'hFF;

    typedef enum logic [1:0] {
        ST_DOWN  = 2'd0,
        ST_IDLE  = 2'd1,
        ST_FRAME = 2'd2
    } fsm_state_e;

    // Read-select encoding; values 0..5 also index the shadow counter array.
    localparam logic [2:0] SEL_UP_CYCLES   = 3'd0;
    localparam logic [2:0] SEL_LINK_DROPS  = 3'd1;
    localparam logic [2:0] SEL_GOOD_FRAMES = 3'd2;
    localparam logic [2:0] SEL_BAD_FRAMES  = 3'd3;
    localparam logic [2:0] SEL_ERR_WORDS   = 3'd4;
    localparam logic [2:0] SEL_NIDLE_WORDS = 3'd5;
    localparam logic [2:0] SEL_CAP_DATA    = 3'd6;
    localparam logic [2:0] SEL_CAP_CTRL    = 3'd7;

    localparam int NUM_CNT = 6;

endpackage

// File: rtl/xgmii_mon_if.sv
// Bus interface of the XGMII link monitor.
// master : the side that drives XGMII words, link status, clear/snap and
//          read requests (PCS wrapper, VIO or register block).
// slave  : the monitor itself, returning rd_data / rd_valid.
interface xgmii_mon_if #(
    parameter int CHANNELS = 2,
    parameter int CNT_W    = 64
);
    localparam int CH_W = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

    logic [CHANNELS-1:0]    link_up;
    logic [64*CHANNELS-1:0] xgmii_rxd;
    logic [8*CHANNELS-1:0]  xgmii_rxc;
    logic [CHANNELS-1:0]    clear;
    logic                   snap;
    logic                   rd_en;
    logic [CH_W-1:0]        rd_ch;
    logic [2:0]             rd_sel;
    logic [CNT_W-1:0]       rd_data;
    logic                   rd_valid;

    modport master (
        output link_up, xgmii_rxd, xgmii_rxc, clear, snap, rd_en, rd_ch, rd_sel,
        input  rd_data, rd_valid
    );

    modport slave (
        input  link_up, xgmii_rxd, xgmii_rxc, clear, snap, rd_en, rd_ch, rd_sel,
        output rd_data, rd_valid
    );
endinterface

// File: rtl/xgmii_mon_chan.sv
// One channel of the XGMII link monitor: character decode, DOWN/IDLE/FRAME
// frame-delimiting FSM, saturating live counters, snapshot shadows and (with
// XGMII_MON_CAPTURE_EN defined) capture of the last non-IDLE word.
// Ports:
//   clk, rst      core clock, synchronous active-high reset
//   link_up       PCS receive link status
//   rxd, rxc      one XGMII word (8 lanes) and its control flags
//   clear         zero the live counters (and capture)
//   snap          copy live counters (and capture) to the shadows
//   shadow        shadow counters indexed by the SEL_* encoding
//   cap_shadow    shadow {rxc, rxd} capture (only with XGMII_MON_CAPTURE_EN)
module xgmii_mon_chan
    import xgmii_mon_pkg::*;
#(
    parameter int CNT_W = 64
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          link_up,
    input  logic [63:0]                   rxd,
    input  logic [7:0]                    rxc,
    input  logic                          clear,
    input  logic                          snap,
`ifdef XGMII_MON_CAPTURE_EN
    output logic [71:0]                   cap_shadow,
`endif
    output logic [NUM_CNT-1:0][CNT_W-1:0] shadow
);

    fsm_state_e       state;
    logic             err_flag;
    logic             link_up_q;
    logic             start_w, term_w, err_w, idle_w;
    logic             good_ev, bad_ev;
    logic             active;
    logic [CNT_W-1:0] up_cnt, drop_cnt, good_cnt, bad_cnt, err_cnt, nidle_cnt;

    function automatic logic [CNT_W-1:0] bump(input logic [CNT_W-1:0] v, input logic ev);
        return (ev && (v != '1)) ? v + 1'b1 : v;
    endfunction

    // START is only legal in lane 0 or lane 4; TERM/ERROR may sit in any lane.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
        term_w  = 1'b0;
        err_w   = 1'b0;
        start_w = (rxc[0] && rxd[7:0] == XGMII_START) ||
                  (rxc[4] && rxd[39:32] == XGMII_START);
        for (int k = 0; k < 8; k++) begin
            if (rxc[k] && rxd[8*k +: 8] == XGMII_TERM)  term_w = 1'b1;
            if (rxc[k] && rxd[8*k +: 8] == XGMII_ERROR) err_w  = 1'b1;
        end
        idle_w = (rxc == IDLE_C) && (rxd == IDLE_D);
    end

    // Frame outcome for this cycle; TERM takes priority over a repeated START.
    always_comb begin
        good_ev = 1'b0;
        bad_ev  = 1'b0;
        if (!link_up) begin
            bad_ev = (state == ST_FRAME);
        end else if (state == ST_FRAME) begin
            if (term_w) begin
                if (err_flag || err_w) bad_ev  = 1'b1;
                else                   good_ev = 1'b1;
            end else if (start_w) begin
                bad_ev = 1'b1;
            end
        end
    end

    // DOWN words (including the relink cycle) are never decoded.
    assign active = (state != ST_DOWN);

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
        if (rst) begin
            state     <= ST_DOWN;
            err_flag  <= 1'b0;
            link_up_q <= 1'b0;
        end else begin
            link_up_q <= link_up;
            if (!link_up) begin
                state <= ST_DOWN;
            end else begin
                case (state)
                    ST_DOWN: state <= ST_IDLE;
                    ST_IDLE: begin
                        if (start_w) begin
                            state    <= ST_FRAME;
                            err_flag <= 1'b0;
                        end
                    end
                    ST_FRAME: begin
                        if (term_w)       state    <= ST_IDLE;
                        else if (start_w) err_flag <= 1'b0;
                        else if (err_w)   err_flag <= 1'b1;
                    end
                    default: state <= ST_DOWN;
                endcase
            end
        end
    end

    // Live counters: clear beats any same-cycle increment.
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            up_cnt    <= '0;
            drop_cnt  <= '0;
            good_cnt  <= '0;
            bad_cnt   <= '0;
            err_cnt   <= '0;
            nidle_cnt <= '0;
        end else begin
            up_cnt    <= bump(up_cnt,    link_up);
            drop_cnt  <= bump(drop_cnt,  link_up_q && !link_up);
            good_cnt  <= bump(good_cnt,  good_ev);
            bad_cnt   <= bump(bad_cnt,   bad_ev);
            err_cnt   <= bump(err_cnt,   active && err_w);
            nidle_cnt <= bump(nidle_cnt, active && !idle_w);
        end
    end

    // Shadows sample the registered live values, so a same-cycle clear or
    // increment is not seen by the snapshot.
    always_ff @(posedge clk) begin
        // NOTE: the shadow array is built from flops, not RAM, so it can and does take the reset.
        if (rst) begin
            shadow <= '0;
        end else if (snap) begin
            shadow[SEL_UP_CYCLES]   <= up_cnt;
            shadow[SEL_LINK_DROPS]  <= drop_cnt;
            shadow[SEL_GOOD_FRAMES] <= good_cnt;
            shadow[SEL_BAD_FRAMES]  <= bad_cnt;
            shadow[SEL_ERR_WORDS]   <= err_cnt;
            shadow[SEL_NIDLE_WORDS] <= nidle_cnt;
        end
    end

`ifdef XGMII_MON_CAPTURE_EN
    logic [71:0] cap_q;

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            cap_q <= '0;
        end else if (active && !idle_w) begin
            cap_q <= {rxc, rxd};
        end
    end

    always_ff @(posedge clk) begin
        if (rst)       cap_shadow <= '0;
        else if (snap) cap_shadow <= cap_q;
    end
`endif

endmodule

// File: rtl/xgmii_link_monitor.sv
// Multi-channel XGMII receive-side link monitor (top level).
// Instantiates one xgmii_mon_chan per channel and provides the registered
// shadow read port. Optional last-word capture: define XGMII_MON_CAPTURE_EN
// (requires CNT_W = 64); otherwise rd_sel 6/7 read 0.
// Ports:
//   clk, rst   core clock, synchronous active-high reset
//   bus        xgmii_mon_if slave: link_up, xgmii_rxd/rxc, clear, snap,
//              rd_en/rd_ch/rd_sel in; rd_data/rd_valid out (one cycle later)
module xgmii_link_monitor
    import xgmii_mon_pkg::*;
#(
    parameter int CHANNELS = 2,
    parameter int CNT_W    = 64
) (
    input  logic        clk,
    input  logic        rst,
    xgmii_mon_if.slave  bus
);

    localparam int CH_W = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

    logic [NUM_CNT-1:0][CNT_W-1:0] shadow [CHANNELS];
`ifdef XGMII_MON_CAPTURE_EN
    logic [71:0]                   cap_shadow [CHANNELS];
`endif
    logic [CNT_W-1:0]              rd_mux;

    for (genvar g = 0; g < CHANNELS; g++) begin : g_chan
        xgmii_mon_chan #(.CNT_W(CNT_W)) u_chan (
            .clk        (clk),
            .rst        (rst),
            .link_up    (bus.link_up[g]),
            .rxd        (bus.xgmii_rxd[64*g +: 64]),
            .rxc        (bus.xgmii_rxc[8*g +: 8]),
            .clear      (bus.clear[g]),
            .snap       (bus.snap),
`ifdef XGMII_MON_CAPTURE_EN
            .cap_shadow (cap_shadow[g]),
`endif
            .shadow     (shadow[g])
        );
    end

    // Out-of-range channel or unimplemented select reads as zero.
    always_comb begin
        rd_mux = '0;
        if (int'(bus.rd_ch) < CHANNELS) begin
            case (bus.rd_sel)
`ifdef XGMII_MON_CAPTURE_EN
                SEL_CAP_DATA: rd_mux = CNT_W'(cap_shadow[bus.rd_ch][63:0]);
                SEL_CAP_CTRL: rd_mux = CNT_W'(cap_shadow[bus.rd_ch][71:64]);
`endif
                SEL_UP_CYCLES, SEL_LINK_DROPS, SEL_GOOD_FRAMES,
                SEL_BAD_FRAMES, SEL_ERR_WORDS, SEL_NIDLE_WORDS:
                    rd_mux = shadow[bus.rd_ch][bus.rd_sel];
                default: rd_mux = '0;
            endcase
        end
    end

    // rd_data holds its last value between reads.
    always_ff @(posedge clk) begin
        if (rst) begin
            bus.rd_data  <= '0;
            bus.rd_valid <= 1'b0;
        end else begin
            bus.rd_valid <= bus.rd_en;
            if (bus.rd_en) bus.rd_data <= rd_mux;
        end
    end

endmodule

// File: tb/tb_xgmii_link_monitor.sv
// Self-checking bench for xgmii_link_monitor (3 channels). Counter width is
// 32 in the default build and 64 when XGMII_MON_CAPTURE_EN is defined.
module tb_xgmii_link_monitor;

    localparam int CH = 3;
`ifdef XGMII_MON_CAPTURE_EN
    localparam int TB_CNT_W = 64;
    localparam logic [63:0] EXP_CAP_D = 64'h0123_4567_89AB_CDEF;
    localparam logic [63:0] EXP_CAP_C = 64'h01;
`else
    localparam int TB_CNT_W = 32;
    localparam logic [63:0] EXP_CAP_D = 64'h0;
    localparam logic [63:0] EXP_CAP_C = 64'h0;
`endif
    localparam int TB_CH_W = 2;

    localparam logic [63:0] W_IDLE_D = 64'h0707_0707_0707_0707;
    localparam logic [7:0]  W_IDLE_C = 8'hFF;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    xgmii_mon_if #(.CHANNELS(CH), .CNT_W(TB_CNT_W)) bus ();

    xgmii_link_monitor #(.CHANNELS(CH), .CNT_W(TB_CNT_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Scoreboard of pending reads.
    logic [63:0] exp_q[$];
    string       name_q[$];
    logic [63:0] last_exp = '0;
    logic        mon_en = 1'b0;

    always @(negedge clk) begin
        if (mon_en) begin
            if (bus.rd_valid) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_rd_valid", 64'(bus.rd_valid), 64'd0);
                end else begin
                    last_exp = exp_q.pop_front();
                    check(name_q.pop_front(), 64'(bus.rd_data), last_exp);
                end
            end else begin
                check("rd_data_hold", 64'(bus.rd_data), last_exp);
            end
        end
    end

    typedef struct {
        int          phase;
        int          ch;
        int          sel;
        logic [63:0] exp;
        string       name;
    } rd_vec_t;

    rd_vec_t vecs[$];

    function automatic void add(input int p, input int c, input int s, input logic [63:0] e, input string n);
        rd_vec_t v;
        v.phase = p; v.ch = c; v.sel = s; v.exp = e; v.name = n;
        vecs.push_back(v);
    endfunction

    task automatic do_read(input int ch, input int sel, input logic [63:0] exp, input string name);
        logic [31:0] chv;
        logic [31:0] selv;
        chv  = ch;
        selv = sel;
        bus.rd_en  = 1'b1;
        bus.rd_ch  = chv[TB_CH_W-1:0];
        bus.rd_sel = selv[2:0];
        exp_q.push_back(exp);
        name_q.push_back(name);
        @(negedge clk);
        bus.rd_en = 1'b0;
        #1;
        check({name, "_rd_valid_latency"}, 64'(exp_q.size()), 64'd0);
        exp_q.delete();
        name_q.delete();
    endtask

    task automatic run_phase(input int p);
        foreach (vecs[i]) begin
            if (vecs[i].phase == p) do_read(vecs[i].ch, vecs[i].sel, vecs[i].exp, vecs[i].name);
        end
    endtask

    task automatic send(input int ch, input logic [63:0] d, input logic [7:0] c);
        bus.xgmii_rxd[ch*64 +: 64] = d;
        bus.xgmii_rxc[ch*8 +: 8]   = c;
        @(negedge clk);
        bus.xgmii_rxd[ch*64 +: 64] = W_IDLE_D;
        bus.xgmii_rxc[ch*8 +: 8]   = W_IDLE_C;
    endtask

    task automatic pulse_snap();
        bus.snap = 1'b1;
        @(negedge clk);
        bus.snap = 1'b0;
    endtask

    task automatic pulse_clear(input logic [CH-1:0] m);
        bus.clear = m;
        @(negedge clk);
        bus.clear = '0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        // phase 0: after reset, nothing snapped
        add(0, 0, 0, 64'd0, "rst_up");
        add(0, 1, 2, 64'd0, "rst_good");
        // phase 1: 100 idle cycles with link up
        add(1, 0, 0, 64'd100, "idle_up_ch0");
        add(1, 1, 0, 64'd100, "idle_up_ch1");
        add(1, 0, 5, 64'd0, "idle_nidle");
        add(1, 0, 1, 64'd0, "idle_drops");
        // phase 2: good frame on ch0
        add(2, 0, 2, 64'd1, "good_good");
        add(2, 0, 3, 64'd0, "good_bad");
        add(2, 0, 5, 64'd8, "good_nidle");
        add(2, 0, 4, 64'd0, "good_err");
        // phase 3: errored frame on ch1
        add(3, 1, 3, 64'd1, "errf_bad");
        add(3, 1, 4, 64'd1, "errf_err");
        add(3, 1, 2, 64'd0, "errf_good");
        add(3, 1, 5, 64'd5, "errf_nidle");
        // phase 4: double START on ch2
        add(4, 2, 3, 64'd1, "dstart_bad");
        add(4, 2, 2, 64'd1, "dstart_good");
        // phase 5: link drop mid-frame on ch0
        add(5, 0, 1, 64'd1, "drop_drops");
        add(5, 0, 3, 64'd1, "drop_bad");
        add(5, 0, 2, 64'd0, "drop_good");
        add(5, 0, 5, 64'd5, "drop_nidle");
        // phase 6: clear and increment in same cycle
        add(6, 0, 0, 64'd0, "clr_inc_up");
        // phase 7/8: snap and clear in same cycle, then a later snap
        add(7, 1, 5, 64'd5, "snapclr_nidle");
        add(7, 1, 3, 64'd1, "snapclr_bad");
        add(8, 1, 5, 64'd0, "after_clr_nidle");
        add(8, 1, 3, 64'd0, "after_clr_bad");
        // phase 9: capture select and out-of-range channel
        add(9, 0, 6, EXP_CAP_D, "cap_data");
        add(9, 0, 7, EXP_CAP_C, "cap_ctrl");
        add(9, 3, 0, 64'd0, "bad_ch_up");
        add(9, 3, 2, 64'd0, "bad_ch_good");
        // phase 10/11: saturation (32-bit build)
        add(10, 2, 0, 64'hFFFF_FFFF, "sat_up");
        add(11, 2, 0, 64'hFFFF_FFFF, "sat_up_hold");

        rst           = 1'b1;
        bus.link_up   = '0;
        bus.xgmii_rxd = {CH{W_IDLE_D}};
        bus.xgmii_rxc = {CH{W_IDLE_C}};
        bus.clear     = '0;
        bus.snap      = 1'b0;
        bus.rd_en     = 1'b0;
        bus.rd_ch     = '0;
        bus.rd_sel    = '0;
        repeat (3) @(negedge clk);
        check("rst_rd_valid", 64'(bus.rd_valid), 64'd0);
        check("rst_rd_data", 64'(bus.rd_data), 64'd0);
        rst    = 1'b0;
        mon_en = 1'b1;
        run_phase(0);

        bus.link_up = '1;
        repeat (100) @(negedge clk);
        pulse_snap();
        run_phase(1);

        pulse_clear(3'b001);
        send(0, 64'h5555_5555_5555_55FB, 8'h01);
        for (int i = 0; i < 6; i++) send(0, 64'hA5A5_0000_0000_0000 + 64'(i), 8'h00);
        send(0, 64'h0707_0707_FDAA_BBCC, 8'hF8);
        repeat (2) @(negedge clk);
        pulse_snap();
        run_phase(2);

        pulse_clear(3'b010);
        send(1, 64'h5555_5555_5555_55FB, 8'h01);
        send(1, 64'h2222_2222_2222_2222, 8'h00);
        send(1, 64'h1111_1111_11FE_1111, 8'h04);
        send(1, 64'h3333_3333_3333_3333, 8'h00);
        send(1, 64'h0707_0707_0707_07FD, 8'hFF);
        repeat (2) @(negedge clk);
        pulse_snap();
        run_phase(3);

        pulse_clear(3'b100);
        send(2, 64'hDDDD_DDFB_0707_0707, 8'h1F);
        send(2, 64'h4444_4444_4444_4444, 8'h00);
        send(2, 64'h5555_5555_5555_55FB, 8'h01);
        send(2, 64'h6666_6666_6666_6666, 8'h00);
        send(2, 64'h0707_0707_FDAA_BBCC, 8'hF8);
        repeat (2) @(negedge clk);
        pulse_snap();
        run_phase(4);

        pulse_clear(3'b001);
        send(0, 64'h5555_5555_5555_55FB, 8'h01);
        send(0, 64'h7777_7777_7777_7777, 8'h00);
        send(0, 64'h8888_8888_8888_8888, 8'h00);
        bus.link_up[0] = 1'b0;
        repeat (5) @(negedge clk);
        bus.link_up[0] = 1'b1;
        send(0, 64'h5555_5555_5555_55FB, 8'h01);   // relink word: not decoded
        send(0, 64'h9999_9999_9999_9999, 8'h00);
        send(0, 64'h0707_0707_0707_07FD, 8'hFF);   // TERM while IDLE: no frame
        repeat (2) @(negedge clk);
        pulse_snap();
        run_phase(5);

        pulse_clear(3'b001);
        pulse_snap();
        run_phase(6);

        bus.clear = 3'b010;
        bus.snap  = 1'b1;
        @(negedge clk);
        bus.clear = '0;
        bus.snap  = 1'b0;
        run_phase(7);
        pulse_snap();
        run_phase(8);

        send(0, 64'h0123_4567_89AB_CDEF, 8'h01);
        repeat (3) @(negedge clk);
        pulse_snap();
        run_phase(9);

`ifndef XGMII_MON_CAPTURE_EN
        force dut.g_chan[2].u_chan.up_cnt = 32'hFFFF_FFF0;
        #1;
        release dut.g_chan[2].u_chan.up_cnt;
        repeat (30) @(negedge clk);
        pulse_snap();
        run_phase(10);
        repeat (10) @(negedge clk);
        pulse_snap();
        run_phase(11);
`endif

        repeat (3) @(negedge clk);
        check("scoreboard_empty", 64'(exp_q.size()), 64'd0);
        mon_en = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
